ripple_add_sequencer: RTL and testbench
=======================================

# ripple_add_sequencer

Multi-cycle WIDTH-bit adder/subtractor built around one shared 4-bit ripple adder slice (`Ripple_adder`). The sequencer latches a pair of operands through a valid/ready handshake. It feeds them through the slice one nibble per cycle, least-significant nibble first, and chains the carry through a register between cycles. It returns the assembled result with carry and signed-overflow flags through a second valid/ready handshake. The block trades latency for area wherever a wide add is needed infrequently.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and ≥ 8. N = WIDTH/4 nibbles.

Ports (bit 0 = LSB on every vector):
- `clk` input 1: single clock, all state rises on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand request.
- `in_ready` output 1: high only in IDLE.
- `op_a` input WIDTH: operand A, sampled on accept.
- `op_b` input WIDTH: operand B, sampled on accept.
- `sub` input 1: 0 = A+B, 1 = A−B. Sampled on accept.
- `out_valid` output 1: result available (DONE state).
- `out_ready` input 1: consumer accepts the result.
- `result` output WIDTH: sum or difference, registered.
- `carry_out` output 1: carry out of the MSB nibble. For subtract, 1 = no borrow.
- `overflow` output 1: two's-complement signed overflow.
- `busy` output 1: high in RUN or DONE.

## Operation
- **States:** IDLE, RUN, DONE. Encoding is free.
- **Accept:** an accept occurs when `in_valid && in_ready` at a posedge. On accept:
  - latch `a_r = op_a`;
  - latch `b_r = sub ? ~op_b : op_b`;
  - set `carry_r = sub`;
  - set `idx = 0`;
  - go to RUN.
- **RUN, each cycle:**
  - The slice inputs are `a_r[4*idx +: 4]`, `b_r[4*idx +: 4]` and `carry_r`.
  - On the posedge, the slice sum is written to `result[4*idx +: 4]` and the slice carry to `carry_r`.
  - When `idx == N−1`, go to DONE. Otherwise increment `idx`.
- **Results:**
  - `carry_out` = `carry_r` after the last nibble.
  - `overflow` = (`a_r[WIDTH−1] == b_r[WIDTH−1]`) && (`result[WIDTH−1] != a_r[WIDTH−1]`), registered on the transition into DONE.
- **DONE:**
  - `out_valid = 1`.
  - `result`, `carry_out` and `overflow` are held stable until `out_ready` is sampled high.
  - Then go to IDLE. `out_valid` drops on the next cycle.
- **Ignored inputs:**
  - `in_valid`, `op_a`, `op_b` and `sub` are ignored in RUN and DONE.
  - Operand changes after the accept edge have no effect.
- **Output meaning:** `result` is only meaningful while `out_valid` is high. During RUN it is partially updated.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH. No saturation.
- **Reset:** reset asserted in any state, including mid-RUN, aborts the operation immediately. No result is emitted.

## Timing
- **Reset values:**
  - `in_ready` = 1;
  - `out_valid`, `busy`, `carry_out`, `overflow` = 0;
  - `result` = 0;
  - state = IDLE, `idx` = 0, `carry_r` = 0.
- **Output derivation:**
  - `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from inputs.
  - `in_ready` may therefore be used to gate `in_valid` upstream without a loop.
- **Latency:**
  - Accept at posedge E0. Nibble k is processed at posedge E(k+1).
  - `out_valid` rises after posedge EN, i.e. N cycles after accept (4 cycles for WIDTH = 16).
- **Throughput:**
  - Zero-wait consumer: `out_ready` is sampled high at the first DONE posedge, giving IDLE one cycle later.
  - The minimum accept-to-accept spacing is therefore N+2 cycles.
- **Backpressure:** DONE persists indefinitely while `out_ready` = 0, with outputs unchanged.
- **Critical path:** one 4-bit ripple (4 full-adder delays) plus the result/carry register setup.

## Test plan
- **Basic add, WIDTH=16:** `op_a`=0x00FF, `op_b`=0x0001, `sub`=0, `out_ready`=1 → `result`=0x0100, `carry_out`=0, `overflow`=0. `out_valid` asserts exactly 4 cycles after accept, and `in_ready` is low throughout RUN/DONE.
- **Wrap and signed overflow:**
  - 0xFFFF+0x0001 → 0x0000, `carry_out`=1, `overflow`=0.
  - 0x7FFF+0x0001 → 0x8000, `carry_out`=0, `overflow`=1.
- **Subtract:**
  - 0x8000−0x0001 (`sub`=1) → 0x7FFF, `carry_out`=1, `overflow`=1.
  - 0x0003−0x0005 → 0xFFFE, `carry_out`=0, `overflow`=0.
- **Backpressure and ignored inputs:**
  - Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `out_valid` stays 1.
  - Toggle `in_valid`/`op_a` during RUN → result unaffected, no second accept.
- **Reset mid-operation:** assert `rst_n`=0 at the 2nd RUN cycle → all outputs return to reset values asynchronously. After release, a new 0x1234+0x1111 → 0x2345 with normal latency.
- **Random regression:** 1000 back-to-back random operands and `sub` values with random `out_ready` stalls, checked against a behavioural WIDTH-bit model. Repeat at WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/ripple_add_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor. A single 4-bit ripple slice is reused
// once per nibble, LSB nibble first, with the carry chained through a register.
// Operands come in and the result goes out through valid/ready handshakes.

// 4-bit ripple-carry slice: four chained full adders.
module Ripple_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

module ripple_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic [3:0]        sl_a, sl_b, sl_sum;
    logic              sl_cout;

    // Nibble offset is idx*4, formed by concatenation to keep the index width exact.
    assign sl_a = a_q[{idx_q, 2'b00} +: 4];
    assign sl_b = b_q[{idx_q, 2'b00} +: 4];

    Ripple_adder u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // Next-state and datapath updates: accept in IDLE, one nibble per RUN cycle, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = sl_sum;
                carry_d = sl_cout;
                if (idx_q == LAST) begin
                    // sl_sum[3] is the result MSB being written this cycle.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[3] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            idx_q    <= idx_d;
        end
    end

    // Handshake outputs decode registered state only, so upstream may gate on in_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Scoreboard bench for ripple_add_sequencer: directed corner cases plus a
// random regression against an integer-arithmetic reference model.
module tb_ripple_add_sequencer;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, sub;
    logic [W-1:0] op_a, op_b, result;
    logic         out_valid, out_ready, carry_out, overflow, busy;
    logic         rnd_ready;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    ripple_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, not a nibble-by-nibble ripple.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa, sb_v, full, mx, mn;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        full = s ? (sa - sb_v) : (sa + sb_v);
        mx   = (longint'(1) << (W - 1)) - 1;
        mn   = -(longint'(1) << (W - 1));
        e.r  = full[W-1:0];
        e.v  = (full > mx) || (full < mn);
        e.c  = s ? (a >= b) : (((longint'(a) + longint'(b)) >> W) != 0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic v);
        exp_t e;
        e.r = r; e.c = c; e.v = v;
        return e;
    endfunction

    // Monitor: a result is consumed on a posedge where out_valid && out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.r);
                chk("carry_out", carry_out, e.c);
                chk("overflow", overflow, e.v);
            end
        end
    end

    // Random consumer stalls, driven just after the posedge.
    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", in_ready, 1);
        in_valid = 1'b1; op_a = a; op_b = b; sub = s;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    endtask

    // Called right after issue(): expects N RUN cycles then DONE.
    task automatic lat_check(input string nm);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk({nm, "_run"}, {out_valid, in_ready, busy}, 3'b001);
        end
        @(negedge clk);
        chk({nm, "_done"}, {out_valid, in_ready, busy}, 3'b101);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        int           n;

        rnd_ready = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_state", {in_ready, out_valid, busy, carry_out, overflow, result},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic add with exact latency.
        issue(16'h00FF, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0));
        lat_check("basic_lat");
        drain("basic_drain");

        // Wrap, signed overflow and subtract corners, back to back.
        issue(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        issue(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        issue(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        issue(16'h0003, 16'h0005, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        drain("corner_drain");

        // Backpressure with input noise during RUN and DONE.
        out_ready = 1'b0;
        issue(16'h1234, 16'h0F0F, 1'b0, mk(16'h2143, 1'b0, 1'b0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
            n++;
        end
        chk("bp_reach_done", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {out_valid, in_ready, result, carry_out, overflow},
                {1'b1, 1'b0, 16'h2143, 1'b0, 1'b0});
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("bp_no_second_accept", {busy, in_ready}, 2'b01);
        end
        drain("bp_drain");

        // Reset in the 2nd RUN cycle aborts; carry and partial result are non-zero then.
        issue(16'h1113, 16'h0001, 1'b1, mk(16'h1112, 1'b1, 1'b0));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", {in_ready, out_valid, busy, carry_out, overflow, result},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'h1234, 16'h1111, 1'b0, mk(16'h2345, 1'b0, 1'b0));
        lat_check("post_reset_lat");
        drain("post_reset_drain");

        // Random regression with consumer stalls.
        rnd_ready = 1'b1;
        repeat (1000) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            issue(ra, rb, rs, model(ra, rb, rs));
        end
        drain("random_drain");
        rnd_ready = 1'b0;
        out_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
